// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch controller: FSM encoding,
// the NOP presented on bubbles and the sequential PC increment.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_BOOT = 2'd0;
    localparam fetch_state_t ST_RUN  = 2'd1;
    localparam fetch_state_t ST_HALT = 2'd2;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam int          PERF_W    = 32;

    // Instructions are word aligned, so the two byte-offset bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Free-running, wrapping counters of delivered and stalled fetch slots.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_ready,
    output logic [PERF_W-1:0] o_fetch_cnt,
    output logic [PERF_W-1:0] o_stall_cnt
);

    logic [PERF_W-1:0] r_fetch_cnt;
    logic [PERF_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (i_valid && i_ready)
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            if (i_valid && !i_ready)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer in front of a 1-cycle synchronous-read memory.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_ready,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_next_pc;

    // r_fetch_pc is the address whose data is currently on im_rdata, so the
    // memory is always addressed with the value r_fetch_pc will take next.
    always_comb begin
        w_next_pc = r_fetch_pc;
        if (redirect_valid)
            w_next_pc = align_word(redirect_pc);
        else if (r_state == ST_RUN && if_ready)
            w_next_pc = r_fetch_pc + PC_STEP;
    end

    assign im_addr  = {{(32 - IM_AW){1'b0}}, w_next_pc[IM_AW+1:2]};
    assign if_valid = (r_state == ST_RUN) && !redirect_valid;
    assign if_pc    = r_fetch_pc;
    assign if_instr = if_valid ? im_rdata : INSTR_NOP;

    // A stalled valid instruction keeps the FSM in RUN even with fetch_en low.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = fetch_en ? ST_RUN : ST_HALT;
            ST_RUN:  if (!fetch_en && (if_ready || !if_valid)) w_state_next = ST_HALT;
            ST_HALT: if (fetch_en) w_state_next = ST_RUN;
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_next_pc;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk         (CLK),
        .rst_n       (RST_N),
        .i_valid     (if_valid),
        .i_ready     (if_ready),
        .o_fetch_cnt (perf_fetch_cnt),
        .o_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, async reset
// sequence, and randomized traffic against a behavioural fetch-stream model.
module tb_fetch_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    fetch_controller #(.RESET_PC(32'h0), .IM_AW(8)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_ready       (if_ready),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Synchronous-read instruction memory, one cycle of latency.
    always @(posedge CLK) im_rdata <= mem[im_addr[7:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    function automatic vec_t mk(input logic fe, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic ev, input logic [31:0] epc,
                                input logic [31:0] eaddr);
        vec_t v;
        v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        v.einstr = ev ? (32'h1000_0000 + {24'd0, epc[9:2]}) : NOP;
        return v;
    endfunction

    // Behavioural model: a stream of words starting at m_pc, delivered while
    // the fetcher is active; a redirect replaces the stream head.
    bit          m_active;
    logic [31:0] m_pc;
    int unsigned m_fetches;
    int unsigned m_stalls;
    logic [31:0] obs_addr;

    task automatic model_reset();
        m_active  = 1'b0;
        m_pc      = 32'h0;
        m_fetches = 0;
        m_stalls  = 0;
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance one cycle.
    task automatic model_cycle(input logic fe, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
        logic        ev;
        logic [31:0] nxt;
        fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; if_ready = rdy;
        @(negedge CLK);
        ev  = m_active && !rv;
        nxt = rv ? {rpc[31:2], 2'b00} : m_pc + ((m_active && rdy) ? 32'd4 : 32'd0);
        chk("rnd_valid", {31'd0, if_valid}, {31'd0, ev});
        chk("rnd_pc", if_pc, m_pc);
        chk("rnd_instr", if_instr, ev ? mem[m_pc[9:2]] : NOP);
        chk("rnd_addr", im_addr, {24'd0, nxt[9:2]});
        obs_addr = im_addr;
        if (ev && rdy) m_fetches++;
        if (ev && !rdy) m_stalls++;
        m_active = fe || (ev && !rdy);
        m_pc     = nxt;
        @(posedge CLK);
        #1;
    endtask

    vec_t tv[25];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;

        tv[0]  = mk(1, 0, 32'h0,   1, 0, 32'h000, 32'h00);
        tv[1]  = mk(1, 0, 32'h0,   1, 1, 32'h000, 32'h01);
        tv[2]  = mk(1, 0, 32'h0,   1, 1, 32'h004, 32'h02);
        tv[3]  = mk(1, 0, 32'h0,   0, 1, 32'h008, 32'h02);
        tv[4]  = mk(1, 0, 32'h0,   0, 1, 32'h008, 32'h02);
        tv[5]  = mk(1, 0, 32'h0,   0, 1, 32'h008, 32'h02);
        tv[6]  = mk(1, 0, 32'h0,   1, 1, 32'h008, 32'h03);
        tv[7]  = mk(1, 0, 32'h0,   0, 1, 32'h00C, 32'h03);
        tv[8]  = mk(1, 1, 32'h43,  0, 0, 32'h00C, 32'h10);
        tv[9]  = mk(1, 0, 32'h0,   1, 1, 32'h040, 32'h11);
        tv[10] = mk(0, 0, 32'h0,   1, 1, 32'h044, 32'h12);
        tv[11] = mk(0, 0, 32'h0,   1, 0, 32'h048, 32'h12);
        tv[12] = mk(1, 0, 32'h0,   1, 0, 32'h048, 32'h12);
        tv[13] = mk(1, 0, 32'h0,   1, 1, 32'h048, 32'h13);
        tv[14] = mk(0, 0, 32'h0,   1, 1, 32'h04C, 32'h14);
        tv[15] = mk(0, 1, 32'h100, 1, 0, 32'h050, 32'h40);
        tv[16] = mk(0, 0, 32'h0,   1, 0, 32'h100, 32'h40);
        tv[17] = mk(1, 0, 32'h0,   1, 0, 32'h100, 32'h40);
        tv[18] = mk(1, 0, 32'h0,   1, 1, 32'h100, 32'h41);
        tv[19] = mk(0, 1, 32'h208, 1, 0, 32'h104, 32'h82);
        tv[20] = mk(1, 0, 32'h0,   1, 0, 32'h208, 32'h82);
        tv[21] = mk(1, 0, 32'h0,   1, 1, 32'h208, 32'h83);
        tv[22] = mk(0, 0, 32'h0,   0, 1, 32'h20C, 32'h83);
        tv[23] = mk(0, 0, 32'h0,   1, 1, 32'h20C, 32'h84);
        tv[24] = mk(0, 0, 32'h0,   1, 0, 32'h210, 32'h84);

        RST_N = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; if_ready = 1'b1;
        #12;
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_addr", im_addr, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // Directed table: vector 0 is the BOOT cycle right after release.
        for (int k = 0; k < 25; k++) begin
            fetch_en = tv[k].fe; redirect_valid = tv[k].rv;
            redirect_pc = tv[k].rpc; if_ready = tv[k].rdy;
            @(negedge CLK);
            chk($sformatf("tv%0d_valid", k), {31'd0, if_valid}, {31'd0, tv[k].ev});
            chk($sformatf("tv%0d_pc", k), if_pc, tv[k].epc);
            chk($sformatf("tv%0d_instr", k), if_instr, tv[k].einstr);
            chk($sformatf("tv%0d_addr", k), im_addr, tv[k].eaddr);
            @(posedge CLK); #1;
        end

        // Asynchronous reset in the middle of a running stream.
        fetch_en = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #3;
        chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("async_rst_pc", if_pc, 32'h0);
        chk("async_rst_instr", if_instr, NOP);
        chk("async_rst_addr", im_addr, 32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("reboot_valid", {31'd0, if_valid}, 32'd0);
        @(posedge CLK); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("restart%0d_valid", k), {31'd0, if_valid}, 32'd1);
            chk($sformatf("restart%0d_pc", k), if_pc, 32'(4 * k));
            chk($sformatf("restart%0d_instr", k), if_instr, 32'h1000_0000 + k);
            @(posedge CLK); #1;
        end

        // Model-checked phase: memory-index wrap, then random traffic.
        RST_N = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        model_reset();
        model_cycle(1, 1, 32'h3F8, 1);
        model_cycle(1, 0, 32'h0, 1);
        model_cycle(1, 0, 32'h0, 1);
        chk("wrap_addr", obs_addr, 32'h0);
        model_cycle(1, 0, 32'h0, 0);
        model_cycle(1, 0, 32'h0, 1);
        chk("wrap_pc", if_pc, 32'h404);

        for (int n = 0; n < 1500; n++) begin
            model_cycle($urandom_range(0, 7) != 0,
                        $urandom_range(0, 15) == 0,
                        $urandom(),
                        $urandom_range(0, 3) != 0);
        end

`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, m_fetches);
        chk("perf_stall_cnt", perf_stall_cnt, m_stalls);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
